// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input front end for the game tops. Each switch channel is synchronised,
// debounced, and turned into press/release pulses with optional auto-repeat.
// A chord detector pulses once when every channel is held, which is the game
// start condition.
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN
//   defined   -> per-channel hold counters generate auto-repeat press pulses
//   undefined -> no hold counters; one o_Press pulse per accepted press
//
// Ports:
//   i_Clk      system clock
//   i_Reset    synchronous active-high reset, priority over everything
//   i_Buttons  raw asynchronous switch levels, 1 = pressed
//   o_Level    debounced level per channel
//   o_Press    1-cycle pulse on accepted press and on each auto-repeat
//   o_Release  1-cycle pulse on accepted release
//   o_Chord    1-cycle pulse when o_Level becomes all-ones
//   o_Any      OR of o_Level (combinational)
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int NUM_BUTTONS    = 4,
  parameter int DEBOUNCE_LIMIT = 25000,
  parameter int REPEAT_DELAY   = 12500000,
  parameter int REPEAT_PERIOD  = 2500000
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [NUM_BUTTONS-1:0] i_Buttons,
  output logic [NUM_BUTTONS-1:0] o_Level,
  output logic [NUM_BUTTONS-1:0] o_Press,
  output logic [NUM_BUTTONS-1:0] o_Release,
  output logic                   o_Chord,
  output logic                   o_Any
);

  // Elaboration-time parameter checks.
  if (NUM_BUTTONS < 1 || NUM_BUTTONS > 16) begin : g_bad_num_buttons
    $error("button_conditioner: NUM_BUTTONS must be 1..16");
  end
  if (DEBOUNCE_LIMIT < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_LIMIT must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("button_conditioner: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  localparam int             DBW     = $clog2(DEBOUNCE_LIMIT);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_LIMIT - 1);
  localparam logic [DBW-1:0] DB_ONE  = DBW'(1);

  logic [NUM_BUTTONS-1:0] sync1_q;
  logic [NUM_BUTTONS-1:0] sync2_q;
  logic [DBW-1:0]         db_cnt_q [NUM_BUTTONS];
  logic [DBW-1:0]         db_cnt_d [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] level_q,   level_d;
  logic [NUM_BUTTONS-1:0] press_q,   press_d;
  logic [NUM_BUTTONS-1:0] release_q, release_d;
  logic                   chord_q,   chord_d;
  logic [NUM_BUTTONS-1:0] rep_fire;
  logic                   all_next;
  logic                   all_prev;

  // Debounce: count cycles where the synchronised level disagrees with the
  // accepted level; any agreement (glitch back) clears the count. The change
  // is accepted on the edge where the count has already reached LIMIT-1.
  always_comb begin : debounce_comb
    level_d = level_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
        end
      end
    end
  end

  assign all_next = &level_d;
  assign all_prev = &level_q;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int            HW          = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [HW-1:0] HOLD_ONE    = HW'(1);

  logic [HW-1:0] hold_q [NUM_BUTTONS];
  logic [HW-1:0] hold_d [NUM_BUTTONS];

  // Hold counter runs only while the channel stays accepted-high across the
  // edge and the chord is not (about to be) complete. A rising edge sees
  // level_q=0, which clears the counter in the same edge as the press pulse,
  // so the first repeat lands REPEAT_DELAY cycles after the press. Reloading
  // to DELAY-PERIOD spaces later repeats by PERIOD without wrapping.
  always_comb begin : repeat_comb
    rep_fire = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      hold_d[i] = '0;
      if (level_q[i] && level_d[i] && !all_next) begin
        if (hold_q[i] == HOLD_LAST) begin
          rep_fire[i] = 1'b1;
          hold_d[i]   = HOLD_RELOAD;
        end else begin
          hold_d[i] = hold_q[i] + HOLD_ONE;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin : pulse_comb
    press_d   = (level_d & ~level_q) | rep_fire;
    release_d = ~level_d & level_q;
    chord_d   = all_next & ~all_prev;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      chord_q   <= 1'b0;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= i_Buttons;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      chord_q   <= chord_d;
      for (int i = 0; i < NUM_BUTTONS; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign o_Level   = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Chord   = chord_q;
  assign o_Any     = |level_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with NUM_BUTTONS=4, DEBOUNCE_LIMIT=4,
// REPEAT_DELAY=10, REPEAT_PERIOD=3. Expectations follow BUTTON_AUTOREPEAT_EN
// so the same bench covers both builds. Cycle k counts rising edges after the
// input change; inputs change 1ns after an edge and outputs are sampled 1ns
// after the following edges.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int DL = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  localparam int LAT = 2 + DL;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] buttons;
  logic [NB-1:0] level, press, rel;
  logic          chord, any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS   (NB),
    .DEBOUNCE_LIMIT(DL),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Buttons(buttons),
    .o_Level  (level),
    .o_Press  (press),
    .o_Release(rel),
    .o_Chord  (chord),
    .o_Any    (any)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    buttons = '0;
    step();
    step();
    n_checks++;
    if ({level, press, rel, chord, any} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs level=%b press=%b rel=%b chord=%b any=%b required all 0",
               level, press, rel, chord, any);
    end
    rst = 1'b0;
    settle(3);
    n_checks++;
    if ({level, press, rel, chord, any} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle level=%b press=%b rel=%b chord=%b any=%b required all 0",
               level, press, rel, chord, any);
    end
  endtask

  // Press ch0 after edge 0, release after edge 20. Press at 6, release at 26,
  // repeats (if enabled) at 16,19,22,25.
  task automatic test_clean_press();
    logic exp_l, exp_p, exp_r;
    buttons[0] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_l = (k >= LAT) && (k < 20 + LAT);
      exp_p = (k == LAT) || (AR && k >= LAT + RD && k < 20 + LAT && ((k - LAT - RD) % RP) == 0);
      exp_r = (k == 20 + LAT);
      n_checks++;
      if ({level[0], press[0], rel[0], any} !== {exp_l, exp_p, exp_r, exp_l}) begin
        n_fail++;
        $display("FAIL clean_press k=%0d level=%b press=%b rel=%b any=%b required %b %b %b %b",
                 k, level[0], press[0], rel[0], any, exp_l, exp_p, exp_r, exp_l);
      end
      if (k == 20) buttons[0] = 1'b0;
    end
  endtask

  // ch1 toggles every 2 cycles: never stable long enough to be accepted.
  task automatic test_bounce();
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) buttons[1] = ~buttons[1];
      step();
      n_checks++;
      if ({level[1], press[1], rel[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce k=%0d level=%b press=%b rel=%b required 0 0 0",
                 k, level[1], press[1], rel[1]);
      end
    end
    buttons[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      n_checks++;
      if ({level[1], press[1], rel[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_tail k=%0d level=%b press=%b rel=%b required 0 0 0",
                 k, level[1], press[1], rel[1]);
      end
    end
  endtask

  // Hold ch2: press at P=6, repeats at 16,19,22; release after edge 17 is
  // accepted at 23, nothing further.
  task automatic test_autorepeat();
    logic exp_p, exp_l, exp_r;
    buttons[2] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      exp_p = (k == LAT) || (AR && (k == LAT + RD || k == LAT + RD + RP || k == LAT + RD + 2 * RP));
      exp_l = (k >= LAT) && (k < 17 + LAT);
      exp_r = (k == 17 + LAT);
      n_checks++;
      if ({level[2], press[2], rel[2]} !== {exp_l, exp_p, exp_r}) begin
        n_fail++;
        $display("FAIL autorepeat k=%0d level=%b press=%b rel=%b required %b %b %b",
                 k, level[2], press[2], rel[2], exp_l, exp_p, exp_r);
      end
      if (k == 17) buttons[2] = 1'b0;
    end
  endtask

  // Channel i pressed after edge i: presses at 6..9, chord at 9 with press[3].
  // No repeats while all held. ch3 released after edge 49 (accepted at 55);
  // repeats on ch0-2 then return when enabled.
  task automatic test_chord();
    logic [NB-1:0] exp_p, exp_r;
    logic          exp_c;
    logic          saw_rep;
    saw_rep    = 1'b0;
    buttons[0] = 1'b1;
    for (int k = 1; k <= 75; k++) begin
      step();
      exp_c = (k == LAT + 3);
      exp_r = (k == 49 + LAT) ? 4'b1000 : 4'b0000;
      exp_p = (k >= LAT && k <= LAT + 3) ? NB'(1 << (k - LAT)) : '0;
      n_checks++;
      if (chord !== exp_c) begin
        n_fail++;
        $display("FAIL chord_pulse k=%0d chord=%b required %b", k, chord, exp_c);
      end
      if (k <= 49 + LAT) begin
        n_checks++;
        if ({press, rel} !== {exp_p, exp_r}) begin
          n_fail++;
          $display("FAIL chord_hold k=%0d press=%b rel=%b required %b %b",
                   k, press, rel, exp_p, exp_r);
        end
      end else begin
        if (press[2:0] == 3'b111) saw_rep = 1'b1;
        n_checks++;
        if (press[3] !== 1'b0) begin
          n_fail++;
          $display("FAIL chord_released_ch3 k=%0d press3=%b required 0", k, press[3]);
        end
      end
      if (k <= 3) buttons[k] = 1'b1;
      if (k == 49) buttons[3] = 1'b0;
    end
    n_checks++;
    if (saw_rep !== AR) begin
      n_fail++;
      $display("FAIL chord_rearm_repeat saw_repeat=%b required %b", saw_rep, AR);
    end
    buttons = '0;
    settle(LAT + 2);
    n_checks++;
    if ({level, any, chord} !== '0) begin
      n_fail++;
      $display("FAIL chord_all_released level=%b any=%b chord=%b required 0 0 0", level, any, chord);
    end
  endtask

  // ch1 and ch2 change in the same cycle: both pulses coincide.
  task automatic test_simultaneous();
    buttons = 4'b0110;
    settle(LAT);
    n_checks++;
    if ({level, press} !== {4'b0110, 4'b0110}) begin
      n_fail++;
      $display("FAIL simul_press level=%b press=%b required 0110 0110", level, press);
    end
    step();
    step();
    buttons = 4'b0000;
    settle(LAT);
    n_checks++;
    if ({level, rel, press} !== {4'b0000, 4'b0110, 4'b0000}) begin
      n_fail++;
      $display("FAIL simul_release level=%b rel=%b press=%b required 0000 0110 0000", level, rel, press);
    end
    settle(4);
  endtask

  // Reset while ch0 held and accepted; press re-fires 6 cycles after reset.
  task automatic test_reset_mid_hold();
    logic exp_l, exp_p;
    buttons[0] = 1'b1;
    settle(LAT + 2);
    n_checks++;
    if (level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold_pre level0=%b required 1", level[0]);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if ({level, press, rel, chord, any} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold_clear level=%b press=%b rel=%b chord=%b any=%b required all 0",
               level, press, rel, chord, any);
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp_l = (k >= LAT);
      exp_p = (k == LAT);
      n_checks++;
      if ({level[0], press[0]} !== {exp_l, exp_p}) begin
        n_fail++;
        $display("FAIL reset_hold_repress k=%0d level=%b press=%b required %b %b",
                 k, level[0], press[0], exp_l, exp_p);
      end
    end
    buttons[0] = 1'b0;
    settle(LAT + 4);
  endtask

  // Hold ch0 for 40 cycles: one press without auto-repeat, press + 9 repeats
  // (16,19,...,40) with it.
  task automatic test_press_count();
    int cnt;
    int exp_cnt;
    cnt     = 0;
    exp_cnt = AR ? 10 : 1;
    buttons[0] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (press[0]) cnt++;
    end
    n_checks++;
    if (cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL press_count count=%0d required %0d", cnt, exp_cnt);
    end
    buttons[0] = 1'b0;
    settle(LAT + 4);
  endtask

  initial begin
    rst     = 1'b1;
    buttons = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_autorepeat();
    test_chord();
    test_simultaneous();
    test_reset_mid_hold();
    test_press_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
